ex_muldiv: RTL and testbench

- Iterative RV32M multiply/divide unit in the execute stage.
- Runs MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU on the EX operands.
- Holds the hazard unit in stall while it iterates.
- Its registered result is muxed onto the EX ALU result path, so it reaches the EX/MEM register as ALUResult in the cycle the stall releases.

---
 rtl/ex_muldiv.sv | 122 ++++++++++++
 tb/tb_ex_muldiv.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the execute stage: 32 radix-2 steps on
// unsigned magnitudes, sign fix-up on the final step, fast path for special divides.
module ex_muldiv (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] SrcAE,
  input  logic [31:0] SrcBE,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] MulDivResult,
  output logic [1:0]  dbg_state
);

  // Handshake: start is held by EX while busy is high; the op is accepted in IDLE
  // when start && !flush, and the result is consumed in the single done cycle.
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t      state, state_nxt;
  logic [4:0]  counter;
  logic [2:0]  op;
  logic [31:0] mag_b;
  logic [63:0] acc;
  logic        neg_q, neg_r;

  logic        accept, a_signed, b_signed, a_neg, b_neg;
  logic [31:0] mag_a_in, mag_b_in, special_res;
  logic        div_zero, div_ovf, special;

  assign accept   = (state == IDLE) && start && !flush;
  assign a_signed = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                    (funct3 == 3'b100) || (funct3 == 3'b110);
  assign b_signed = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                    (funct3 == 3'b100) || (funct3 == 3'b110);
  assign a_neg    = a_signed && SrcAE[31];
  assign b_neg    = b_signed && SrcBE[31];
  // 0x80000000 negates to itself, which is already its correct unsigned magnitude.
  assign mag_a_in = a_neg ? (~SrcAE + 32'd1) : SrcAE;
  assign mag_b_in = b_neg ? (~SrcBE + 32'd1) : SrcBE;

  assign div_zero    = funct3[2] && (SrcBE == 32'd0);
  assign div_ovf     = funct3[2] && !funct3[0] && (SrcAE == 32'h8000_0000) &&
                       (SrcBE == 32'hFFFF_FFFF);
  assign special     = div_zero || div_ovf;
  assign special_res = div_zero ? (funct3[1] ? SrcAE : 32'hFFFF_FFFF)
                                : (funct3[1] ? 32'd0 : 32'h8000_0000);

  // Multiply: low half holds the shifting multiplier, high half accumulates.
  // Divide: high half is the partial remainder, low half shifts dividend out / quotient in.
  logic [32:0] mul_sum, div_shift, div_rem;
  logic        div_ge;
  logic [63:0] step, prod_s;
  logic [31:0] quo_s, rem_s, final_res;

  assign mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mag_b} : 33'd0);
  assign div_shift = {acc[63:32], acc[31]};
  assign div_ge    = div_shift >= {1'b0, mag_b};
  assign div_rem   = div_ge ? (div_shift - {1'b0, mag_b}) : div_shift;
  assign step      = op[2] ? {div_rem[31:0], acc[30:0], div_ge} : {mul_sum, acc[31:1]};
  assign prod_s    = neg_q ? (~step + 64'd1) : step;
  assign quo_s     = neg_q ? (~step[31:0] + 32'd1) : step[31:0];
  assign rem_s     = neg_r ? (~step[63:32] + 32'd1) : step[63:32];

  always_comb begin
    final_res = prod_s[63:32];
    case (op)
      3'b000:         final_res = prod_s[31:0];
      3'b100, 3'b101: final_res = quo_s;
      3'b110, 3'b111: final_res = rem_s;
      default:        final_res = prod_s[63:32];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = special ? DONE : RUN;
      RUN:     if (counter == 5'd31) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_comb begin
    busy      = rst_n && (accept || (state == RUN));
    done      = (state == DONE) && !flush;
    dbg_state = state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter      <= 5'd0;
      op           <= 3'd0;
      mag_b        <= 32'd0;
      acc          <= 64'd0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      MulDivResult <= 32'd0;
    end else if (accept) begin
      counter <= 5'd0;
      op      <= funct3;
      mag_b   <= mag_b_in;
      acc     <= {32'd0, mag_a_in};
      neg_q   <= a_neg ^ b_neg;
      neg_r   <= a_neg;
      if (special) MulDivResult <= special_res;
    end else if ((state == RUN) && !flush) begin
      acc     <= step;
      counter <= counter + 5'd1;
      if (counter == 5'd31) MulDivResult <= final_res;
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Randomized and directed bench for ex_muldiv: a driver issues M-ops, a monitor
// checks each done pulse against a queue filled from a plain-arithmetic RV32M model.
module tb_ex_muldiv;

  logic        clk, rst_n, start, flush;
  logic [2:0]  funct3;
  logic [31:0] SrcAE, SrcBE;
  logic        busy, done;
  logic [31:0] MulDivResult;
  logic [1:0]  dbg_state;

  int tests = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_res = 32'd0;

  ex_muldiv dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .flush(flush),
    .busy(busy), .done(done), .MulDivResult(MulDivResult), .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    p = 64'd0;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a,
                                    input logic [31:0] b);
    if (!f[2]) return 1'b0;
    if (b == 0) return 1'b1;
    return (f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  // Called right after a rising edge; leaves the bench right after the edge that
  // follows DONE, so a following call starts the next op with no gap.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int lat, lat_exp;
    bit seen, busy_ok;
    lat_exp = is_special(f, a, b) ? 1 : 33;
    exp_q.push_back(model(f, a, b));
    start = 1'b1; funct3 = f; SrcAE = a; SrcBE = b;
    @(negedge clk);
    check("busy_at_start", busy, 1);
    lat = 0; seen = 0; busy_ok = 1;
    while (!seen && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (done) seen = 1;
      else if (!busy) busy_ok = 0;
    end
    check("latency", lat, lat_exp);
    check("busy_while_iterating", busy_ok, 1);
    check("busy_low_in_done", busy, 0);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        tests++;
        errors++;
        $display("FAIL unexpected_done: result 0x%0h with no op pending at %0t",
                 MulDivResult, $time);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("result", MulDivResult, e);
        last_res = e;
      end
    end
  end

  initial begin
    int pulses;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; funct3 = 3'd0; SrcAE = 32'd0; SrcBE = 32'd0;
    repeat (3) @(posedge clk);
    #2;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_result", MulDivResult, 0);
    check("reset_state", dbg_state, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    issue(3'd0, 32'h0000_0007, 32'hFFFF_FFFD);
    check("mul_7_m3", last_res, 32'hFFFF_FFEB);
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("mulhu_ones", last_res, 32'hFFFF_FFFE);
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("mulh_ones", last_res, 32'h0000_0000);
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("mulhsu_ones", last_res, 32'hFFFF_FFFF);
    issue(3'd4, 32'hFFFF_FFF9, 32'd2);
    check("div_m7_2", last_res, 32'hFFFF_FFFD);
    issue(3'd6, 32'hFFFF_FFF9, 32'd2);
    check("rem_m7_2", last_res, 32'hFFFF_FFFF);
    issue(3'd5, 32'd100, 32'd7);
    check("divu_100_7", last_res, 32'h0000_000E);
    issue(3'd7, 32'd100, 32'd7);
    check("remu_100_7", last_res, 32'h0000_0002);
    issue(3'd4, 32'd5, 32'd0);
    check("div_by_zero", last_res, 32'hFFFF_FFFF);
    issue(3'd7, 32'd5, 32'd0);
    check("remu_by_zero", last_res, 32'h0000_0005);
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_overflow", last_res, 32'h8000_0000);
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    check("rem_overflow", last_res, 32'h0000_0000);

    // Abort a MUL in RUN with flush at T+10.
    start = 1'b1; funct3 = 3'd0; SrcAE = $urandom; SrcBE = $urandom;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    check("flush_cycle_state_run", dbg_state, 1);
    @(posedge clk);
    #1 flush = 1'b0; start = 1'b0;
    @(negedge clk);
    check("after_flush_busy", busy, 0);
    check("after_flush_state", dbg_state, 0);
    check("after_flush_result_kept", MulDivResult, last_res);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("flush_no_done", pulses, 0);

    // Flush in IDLE with start high: not accepted.
    @(posedge clk);
    #1 start = 1'b1; flush = 1'b1;
    @(negedge clk);
    check("idle_flush_busy", busy, 0);
    @(posedge clk);
    #1;
    check("idle_flush_state", dbg_state, 0);
    start = 1'b0; flush = 1'b0;
    @(posedge clk);
    #1;

    issue(3'd3, $urandom, $urandom);
    issue(3'd5, $urandom, $urandom_range(1, 1000));

    for (int i = 0; i < 24; i++) begin
      logic [2:0] f;
      f = $urandom_range(0, 7);
      issue(f, rand_operand(), rand_operand());
    end

    // Asynchronous reset in the middle of a DIV.
    start = 1'b1; funct3 = 3'd4; SrcAE = $urandom; SrcBE = $urandom_range(1, 100);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_done", done, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_result", MulDivResult, 0);
    start = 1'b0;
    last_res = 32'd0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(3'd0, 32'd3, 32'd4);
    check("mul_3_4_after_reset", last_res, 32'h0000_000C);

    repeat (3) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
